// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter sharing one async-FIFO write port.
// Optional FIFO_WR_ARB_STATS_EN adds accepted-word and stall counters.
module fifo_wr_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          wfull,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [IDW-1:0]                src_id,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic [IDW:0]                  stat_sel,
  input  logic                          stat_clr,
  output logic [15:0]                   stat_cnt,
`endif
  output logic                          busy
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t                  state_q, state_d;
  logic [IDW-1:0]          owner_q, owner_d;
  logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [7:0]              burst_cnt_q, burst_cnt_d;
  logic [IDW-1:0]          pick;
  logic [IDW-1:0]          owner_next;
  logic                    owner_req;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   owner_data;

  assign owner_req  = req[owner_q];
  assign owner_data = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
  assign owner_next = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;

  // First set request at or above rr_ptr, wrapping past NUM_REQ-1 to 0.
  always_comb begin
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    gnt         = '0;
    winc        = 1'b0;
    wdata       = '0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d     = pick;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        // Grant follows wfull combinationally so a full FIFO is never written.
        gnt[owner_q] = !wfull;
        accept       = owner_req && !wfull;
        winc         = accept;
        if (accept) begin
          wdata       = owner_data;
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
        if (!owner_req || (accept && burst_cnt_q == LAST_BEAT)) begin
          state_d  = IDLE;
          rr_ptr_d = owner_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign src_id = owner_q;
  assign busy   = (state_q == BURST);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] acc_cnt_q [NUM_REQ];
  logic [15:0] stall_cnt_q;
  logic [15:0] stat_cnt_q;
  logic        stall;

  assign stall = (state_q == BURST) && owner_req && wfull;

  // stat_sel MSB set reads the stall counter, otherwise a requester counter.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      for (int i = 0; i < NUM_REQ; i++) acc_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
      stat_cnt_q  <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) acc_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
      stat_cnt_q  <= '0;
    end else begin
      if (accept && acc_cnt_q[owner_q] != 16'hFFFF)
        acc_cnt_q[owner_q] <= acc_cnt_q[owner_q] + 16'd1;
      if (stall && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (stat_sel[IDW])
        stat_cnt_q <= stall_cnt_q;
      else if (int'(stat_sel[IDW-1:0]) < NUM_REQ)
        stat_cnt_q <= acc_cnt_q[stat_sel[IDW-1:0]];
      else
        stat_cnt_q <= '0;
    end
  end

  assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - scoreboard bench for fifo_wr_arb with directed scenarios.
module tb_fifo_wr_arb;
  localparam int DW = 8;
  localparam int NR = 4;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic            wclk = 1'b0;
  logic            wrst_n;
  logic [NR-1:0]   req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   gnt;
  logic            wfull;
  logic            winc;
  logic [DW-1:0]   wdata;
  logic [1:0]      src_id;
  logic            busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [2:0]      stat_sel;
  logic            stat_clr;
  logic [15:0]     stat_cnt;
`endif

  fifo_wr_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .wfull(wfull), .winc(winc), .wdata(wdata), .src_id(src_id),
`ifdef FIFO_WR_ARB_STATS_EN
    .stat_sel(stat_sel), .stat_clr(stat_clr), .stat_cnt(stat_cnt),
`endif
    .busy(busy)
  );

  always #5 wclk = ~wclk;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         c0;
  logic [7:0] words [NR][$];
  exp_t       exp_q [$];
  logic [NR-1:0] acc_s;
  int         acc_at [int];

  always @(posedge wclk) cyc <= cyc + 1;

  // Monitor: every FIFO write must be the next scoreboard entry.
  always @(negedge wclk) begin
    exp_t e;
    acc_s = req & gnt;
    if (wrst_n && winc) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual id=%0d data=%h required none", src_id, wdata);
      end else begin
        e = exp_q.pop_front();
        if (src_id !== e.id || wdata !== e.data) begin
          failures++;
          $display("FAIL write_data actual id=%0d data=%h required id=%0d data=%h",
                   src_id, wdata, e.id, e.data);
        end
      end
      checks++;
      if (gnt !== (4'b0001 << src_id) || wfull !== 1'b0) begin
        failures++;
        $display("FAIL gnt_onehot actual gnt=%b wfull=%b required gnt=%b wfull=0",
                 gnt, wfull, 4'b0001 << src_id);
      end
      acc_at[int'(wdata)] = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int at(input int d);
    return acc_at.exists(d) ? acc_at[d] : -1000;
  endfunction

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      req[i] = (words[i].size() > 0);
      req_data[i*DW +: DW] = (words[i].size() > 0) ? words[i][0] : '0;
    end
  endtask

  task automatic cycle();
    @(posedge wclk);
    #1;
    for (int i = 0; i < NR; i++)
      if (acc_s[i] && words[i].size() > 0) void'(words[i].pop_front());
    refresh();
  endtask

  task automatic load(input int r, input logic [7:0] d);
    words[r].push_back(d);
    exp_q.push_back('{id: 2'(r), data: d});
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    wfull  = 1'b0;
    for (int i = 0; i < NR; i++) words[i].delete();
    exp_q.delete();
    acc_at.delete();
    refresh();
    repeat (2) @(posedge wclk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_winc", winc, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_src_id", src_id, 0);
    chk("rst_busy", busy, 0);
`ifdef FIFO_WR_ARB_STATS_EN
    chk("rst_stat_cnt", stat_cnt, 0);
`endif
    wrst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wrst_n = 1'b0; wfull = 1'b0; req = '0; req_data = '0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_sel = '0; stat_clr = 1'b0;
`endif

    // Single requester, six words: two bursts with one re-arbitration bubble.
    do_reset();
    for (int d = 'hA0; d <= 'hA5; d++) load(0, 8'(d));
    refresh();
    c0 = cyc;
    @(negedge wclk);
    chk("s1_bubble_gnt", gnt, 0);
    chk("s1_bubble_busy", busy, 0);
    drain(40);
    chk("s1_first_word_cycle", at('hA0) - c0, 1);
    chk("s1_last_of_burst_cycle", at('hA3) - c0, 4);
    chk("s1_regrant_cycle", at('hA4) - c0, 6);

    // All four requesting: owners 0,1,2,3,0, four words each, bubble between.
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 4; j++) load(i, 8'(i * 16 + j));
    for (int j = 4; j < 8; j++) load(0, 8'(j));
    refresh();
    c0 = cyc;
    drain(60);
    chk("s2_owner1_start", at('h10) - c0, 6);
    chk("s2_owner3_start", at('h30) - c0, 16);
    chk("s2_owner0_again", at('h04) - c0, 21);
`ifdef FIFO_WR_ARB_STATS_EN
    stat_sel = 3'd2; cycle(); cycle();
    chk("s2_stat_req2", stat_cnt, 4);
    stat_sel = 3'd0; cycle(); cycle();
    chk("s2_stat_req0", stat_cnt, 8);
`endif

    // Back-pressure on owner 2 after two words.
    do_reset();
    for (int d = 'hC0; d <= 'hC3; d++) load(2, 8'(d));
    refresh();
    c0 = cyc;
    cycle(); cycle(); cycle();
    wfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge wclk);
      chk("s3_stall_gnt", gnt, 0);
      chk("s3_stall_winc", winc, 0);
      chk("s3_stall_busy", busy, 1);
      chk("s3_stall_owner", src_id, 2);
      cycle();
    end
    wfull = 1'b0;
    drain(20);
    chk("s3_word1_cycle", at('hC1) - c0, 2);
    chk("s3_resume_cycle", at('hC2) - c0, 8);
    chk("s3_last_cycle", at('hC3) - c0, 9);
`ifdef FIFO_WR_ARB_STATS_EN
    stat_sel = 3'b100; cycle(); cycle();
    chk("s3_stat_stall", stat_cnt, 5);
    stat_clr = 1'b1; cycle();
    stat_clr = 1'b0; cycle(); cycle();
    chk("s3_stat_clr", stat_cnt, 0);
`endif

    // Owner 1 releases after one word; pending 1001 resumes from rr_ptr 2.
    do_reset();
    load(1, 8'hB1);
    refresh();
    c0 = cyc;
    cycle();
    load(3, 8'hB3);
    load(0, 8'hB0);
    refresh();
    drain(30);
    chk("s4_owner1_cycle", at('hB1) - c0, 1);
    chk("s4_owner3_cycle", at('hB3) - c0, 4);
    chk("s4_owner0_cycle", at('hB0) - c0, 7);

    // Asynchronous reset while a word is being offered.
    do_reset();
    for (int d = 'hD0; d <= 'hD3; d++) words[0].push_back(8'(d));
    refresh();
    cycle();
    chk("s5_winc_before", winc, 1);
    #2 wrst_n = 1'b0;
    #1;
    chk("s5_gnt_async", gnt, 0);
    chk("s5_winc_async", winc, 0);
    chk("s5_busy_async", busy, 0);
    for (int i = 0; i < NR; i++) words[i].delete();
    load(1, 8'hE1);
    load(2, 8'hE2);
    refresh();
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    c0 = cyc;
    drain(20);
    chk("s5_owner1_cycle", at('hE1) - c0, 1);
    chk("s5_owner2_cycle", at('hE2) - c0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
